ahb_master: RTL and testbench

AHB_MASTER -- requirements
Module: ahb_master

---
 rtl/ahb_pkg.sv | 18 +
 rtl/ahb_wait_timer.sv | 34 +++
 rtl/ahb_master.sv | 133 +++++++++++++
 tb/tb_ahb_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the master FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } ahb_state_e;

endpackage

// File: rtl/ahb_wait_timer.sv
// Counts consecutive hready-low cycles while a transfer is in flight and
// flags expiry on the cycle the count would reach TIMEOUT_CYCLES.
module ahb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic hready_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (active_i && !hready_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign expire_o = active_i && !hready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ahb_master.sv
// Single-transfer AHB-lite master: one NONSEQ read or write per request.
// Optional hready timeout enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        busy,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        wr_done,
  output logic        err
);

  ahb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wr_done_q, wr_done_d;
  logic        timeout;

`ifdef AHB_MASTER_TIMEOUT_EN
  ahb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i   (HCLK),
    .rst_ni  (HRESET),
    .active_i((state_q == ST_ADDR) || (state_q == ST_DATA)),
    .hready_i(hready),
    .expire_o(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    write_d    = write_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A read wins when both requests are raised together.
        if (rd_req || wr_req) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          write_d = !rd_req;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (timeout) begin
          state_d = ST_ERR;
        end else if (hready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hresp || timeout) begin
          state_d = ST_ERR;
        end else if (hready) begin
          state_d    = ST_IDLE;
          rd_valid_d = !write_q;
          wr_done_d  = write_q;
          if (!write_q) begin
            rdata_d = hrdata;
          end
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      size_q     <= size_d;
      write_q    <= write_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign htrans   = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr    = addr_q;
  assign hwrite   = write_q;
  assign hsize    = size_q;
  assign hwdata   = wdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = (state_q == ST_ERR);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rdata_q;
  assign wr_done  = wr_done_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master with a transfer-level reference model.
// Timeout scenario is exercised when AHB_MASTER_TIMEOUT_EN is defined.
module tb_ahb_master;

  localparam int TO = 4;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] haddr, hwdata, hrdata, req_addr, req_wdata, rd_data;
  logic [1:0]  htrans;
  logic [2:0]  hsize, req_size;
  logic        hwrite, hready, hresp, rd_req, wr_req;
  logic        busy, rd_valid, wr_done, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hwdata   (hwdata),
    .hrdata   (hrdata),
    .hready   (hready),
    .hresp    (hresp),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_size (req_size),
    .busy     (busy),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_done  (wr_done),
    .err      (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  // Transfer-level model: one outstanding transfer, tracked by whether its
  // address phase has been accepted yet.
  logic        m_active, m_addr_done, m_read, m_rd_valid, m_wr_done, m_err;
  logic [31:0] m_addr, m_wdata, m_rd_data;
  logic [2:0]  m_size;
  int          m_waits;
  logic        m_timeout;

`ifdef AHB_MASTER_TIMEOUT_EN
  assign m_timeout = m_active && !hready && (m_waits + 1 == TO);
`else
  assign m_timeout = 1'b0;
`endif

  always @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      m_active <= 0; m_addr_done <= 0; m_read <= 0; m_addr <= 0; m_wdata <= 0;
      m_size <= 0; m_waits <= 0; m_rd_valid <= 0; m_rd_data <= 0; m_wr_done <= 0; m_err <= 0;
    end else begin
      m_rd_valid <= 0;
      m_wr_done  <= 0;
      m_err      <= 0;
      if (!m_active && !m_err) begin
        if (rd_req || wr_req) begin
          m_active <= 1; m_addr_done <= 0; m_waits <= 0; m_read <= rd_req;
          m_addr <= req_addr; m_wdata <= req_wdata; m_size <= req_size;
        end
      end else if (m_active) begin
        m_waits <= hready ? 0 : m_waits + 1;
        if (m_timeout || (m_addr_done && hresp)) begin
          m_active <= 0;
          m_err    <= 1;
        end else if (hready) begin
          if (!m_addr_done) begin
            m_addr_done <= 1;
          end else begin
            m_active   <= 0;
            m_rd_valid <= m_read;
            m_rd_data  <= hrdata;
            m_wr_done  <= !m_read;
          end
        end
      end
    end
  end

  always @(negedge HCLK) begin
    chk("model_busy", busy, m_active | m_err);
    chk("model_htrans", htrans, (m_active && !m_addr_done) ? 32'h2 : 32'h0);
    if (m_active && !m_addr_done) begin
      chk("model_haddr", haddr, m_addr);
      chk("model_hwrite", hwrite, !m_read);
      chk("model_hsize", hsize, m_size);
    end
    if (m_active && m_addr_done && !m_read) chk("model_hwdata", hwdata, m_wdata);
    chk("model_rd_valid", rd_valid, m_rd_valid);
    chk("model_wr_done", wr_done, m_wr_done);
    chk("model_err", err, m_err);
    if (m_rd_valid) chk("model_rd_data", rd_data, m_rd_data);
  end

  initial begin
    rd_req = 0; wr_req = 0; req_addr = 0; req_wdata = 0; req_size = 0;
    hrdata = 0; hready = 1; hresp = 0;
    #1 HRESET = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_htrans", htrans, 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    tick(); tick();
    HRESET = 1;
    tick();

    // Single read, zero wait states
    $display("txn read addr=00000010 size=2 hrdata=deadbeef");
    rd_req = 1; req_addr = 32'h10; req_size = 3'b010; hrdata = 32'hDEADBEEF;
    tick();
    rd_req = 0;
    chk("rd_htrans_t1", htrans, 2'b10);
    chk("rd_haddr_t1", haddr, 32'h10);
    chk("rd_hsize_t1", hsize, 3'b010);
    tick();
    chk("rd_htrans_t2", htrans, 2'b00);
    tick();
    chk("rd_valid_t3", rd_valid, 1);
    chk("rd_data_t3", rd_data, 32'hDEADBEEF);
    tick();
    chk("rd_valid_t4", rd_valid, 0);

    // Write with two data-phase wait states
    $display("txn write addr=00000020 data=12345678 waits=2");
    wr_req = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 3'b010;
    tick();
    wr_req = 0;
    chk("wr_hwrite_t1", hwrite, 1);
    tick();
    chk("wr_hwdata_t2", hwdata, 32'h12345678);
    hready = 0;
    tick();
    chk("wr_hwdata_t3", hwdata, 32'h12345678);
    tick();
    chk("wr_hwdata_t4", hwdata, 32'h12345678);
    chk("wr_done_t4", wr_done, 0);
    hready = 1;
    tick();
    chk("wr_done_t5", wr_done, 1);
    tick();

    // Simultaneous read and write requests
    $display("txn read+write addr=00000030 hrdata=cafe0001");
    rd_req = 1; wr_req = 1; req_addr = 32'h30; req_wdata = 32'h0BADF00D; hrdata = 32'hCAFE0001;
    tick();
    rd_req = 0; wr_req = 0;
    chk("both_hwrite", hwrite, 0);
    tick(); tick();
    chk("both_rd_valid", rd_valid, 1);
    chk("both_wr_done", wr_done, 0);
    chk("both_rd_data", rd_data, 32'hCAFE0001);
    tick();

    // Error response in a read data phase
    $display("txn read addr=00000040 hresp=1");
    rd_req = 1; req_addr = 32'h40; hrdata = 32'hBAD0BAD0;
    tick();
    rd_req = 0;
    tick();
    hresp = 1;
    tick();
    hresp = 0;
    chk("err_pulse", err, 1);
    chk("err_no_rd_valid", rd_valid, 0);
    tick();
    chk("err_busy_after", busy, 0);
    chk("err_pulse_end", err, 0);
    chk("err_no_rd_valid2", rd_valid, 0);
    tick();

    // Back-to-back reads; request held across completion, mid-transfer changes ignored
    $display("txn read addr=00000070 then read addr=00000075 size=0");
    rd_req = 1; req_addr = 32'h70; req_size = 3'b010; hrdata = 32'h11111111;
    tick();
    req_addr = 32'h75; req_size = 3'b000;
    chk("b2b_haddr_hold", haddr, 32'h70);
    tick(); tick();
    chk("b2b_rd_valid1", rd_valid, 1);
    chk("b2b_rd_data1", rd_data, 32'h11111111);
    hrdata = 32'h22222222;
    tick();
    rd_req = 0;
    chk("b2b_htrans2", htrans, 2'b10);
    chk("b2b_haddr2", haddr, 32'h75);
    chk("b2b_hsize2", hsize, 3'b000);
    tick(); tick();
    chk("b2b_rd_data2", rd_data, 32'h22222222);
    tick();

    // Reset asserted during the data phase of a write
    $display("txn write addr=00000050 reset in data phase");
    wr_req = 1; req_addr = 32'h50; req_wdata = 32'hA5A5A5A5; req_size = 3'b001;
    tick();
    wr_req = 0;
    tick();
    chk("rst_pre_hwdata", hwdata, 32'hA5A5A5A5);
    HRESET = 0;
    #1;
    chk("rst_mid_htrans", htrans, 0);
    chk("rst_mid_haddr", haddr, 0);
    chk("rst_mid_hwrite", hwrite, 0);
    chk("rst_mid_hsize", hsize, 0);
    chk("rst_mid_hwdata", hwdata, 0);
    chk("rst_mid_rd_data", rd_data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pulses", {rd_valid, wr_done, err}, 0);
    tick();
    HRESET = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_post_wr_done", wr_done, 0);
      chk("rst_post_busy", busy, 0);
    end

`ifdef AHB_MASTER_TIMEOUT_EN
    $display("txn read addr=00000060 hready stuck low, timeout=%0d", TO);
    rd_req = 1; req_addr = 32'h60; req_size = 3'b010; hready = 0;
    tick();
    rd_req = 0;
    chk("to_htrans_t1", htrans, 2'b10);
    tick(); tick(); tick();
    chk("to_err_t4", err, 0);
    chk("to_htrans_t4", htrans, 2'b10);
    tick();
    chk("to_err_t5", err, 1);
    tick();
    chk("to_busy_t6", busy, 0);
    chk("to_err_t6", err, 0);
    hready = 1;
`else
    $display("txn read addr=00000060 hready low for 12 cycles");
    rd_req = 1; req_addr = 32'h60; req_size = 3'b010; hready = 0;
    tick();
    rd_req = 0;
    for (int i = 0; i < 11; i++) tick();
    chk("wait_busy", busy, 1);
    chk("wait_htrans", htrans, 2'b10);
    chk("wait_no_err", err, 0);
    hready = 1; hrdata = 32'h33333333;
    tick();
    chk("wait_htrans_data", htrans, 2'b00);
    tick();
    chk("wait_rd_valid", rd_valid, 1);
    chk("wait_rd_data", rd_data, 32'h33333333);
`endif
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
